// File: rtl/yarp_pkg.sv
// Shared types and sizing constants for the load/store path.
package yarp_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_t;

  localparam int unsigned DMEM_ROWS  = 32;
  localparam int unsigned VEC_ROWS   = 4;
  localparam int unsigned DMEM_BYTES = 512;
  localparam int unsigned VEC_BITS   = 128;

  typedef logic [VEC_ROWS-1:0][VEC_BITS-1:0] vec_data_t;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational request screening: alignment (only when LSU_MISALIGN_CHK_EN
// is defined) and data-memory range. Vector accesses span VEC_ROWS rows of
// 16 bytes, so the base row must leave room for all of them.
module lsu_addr_check
  import yarp_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        vec_i,
  output logic        err_o
);

  logic misalign;
  logic out_of_range;

`ifdef LSU_MISALIGN_CHK_EN
  // Natural alignment per access width; vectors align to a 16-byte row.
  always_comb begin
    misalign = 1'b0;
    if (vec_i) begin
      misalign = (addr_i[3:0] != 4'd0);
    end else if (size_i == HALF_WORD) begin
      misalign = addr_i[0];
    end else if (size_i == WORD) begin
      misalign = (addr_i[1:0] != 2'd0);
    end
  end
`else
  logic unused_size;
  assign unused_size = ^size_i;

  // Alignment is left to the memory in this build.
  always_comb begin
    misalign = 1'b0;
  end
`endif

  // Range check: scalar against byte count, vector base row against last fitting row.
  always_comb begin
    if (vec_i) begin
      out_of_range = (addr_i[31:4] > 28'(DMEM_ROWS - VEC_ROWS));
    end else begin
      out_of_range = (addr_i >= 32'(DMEM_BYTES));
    end
  end

  assign err_o = misalign | out_of_range;

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store control stage in front of the data memory. One request in
// flight; each accepted request gets exactly one memory cycle (ACCESS) unless
// rejected, then a response held until writeback takes it.
// Build option: LSU_MISALIGN_CHK_EN enables the alignment checks.
//
// state  | meaning
// IDLE   | ready for a request, memory port quiet
// ACCESS | drive latched request to memory for one cycle, capture read data
// RESP   | hold response until rsp_ready_i; may accept the next request
module lsu_mem_ctrl
  import yarp_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic                              req_wr_i,
  input  logic [31:0]                       req_addr_i,
  input  logic [1:0]                        req_size_i,
  input  logic                              req_zero_extnd_i,
  input  logic                              req_vec_i,
  input  logic [31:0]                       req_wdata_i,
  input  logic [VEC_ROWS-1:0][VEC_BITS-1:0] req_vec_wdata_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic                              rsp_err_o,
  output logic [31:0]                       rsp_rdata_o,
  output logic [VEC_ROWS-1:0][VEC_BITS-1:0] rsp_vec_rdata_o,
  output logic                              data_req_o,
  output logic                              data_wr_o,
  output logic [31:0]                       data_addr_o,
  output logic [1:0]                        data_byte_en_o,
  output logic                              data_zero_extnd_o,
  output logic                              is_vector_o,
  output logic [31:0]                       data_wr_data_o,
  output logic [VEC_ROWS-1:0][VEC_BITS-1:0] vec_data_wr_data_o,
  input  logic [31:0]                       data_mem_rd_data_i,
  input  logic [VEC_ROWS-1:0][VEC_BITS-1:0] vec_mem_rd_data_i
);

  lsu_state_t  state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        zext_q, zext_d;
  logic        vec_q, vec_d;
  logic [31:0] wdata_q, wdata_d;
  vec_data_t   vec_wdata_q, vec_wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  vec_data_t   vec_rdata_q, vec_rdata_d;

  logic req_err;
  logic rsp_done;
  logic accept;
  logic in_access;

  lsu_addr_check u_addr_check (
    .addr_i (req_addr_i),
    .size_i (req_size_i),
    .vec_i  (req_vec_i),
    .err_o  (req_err)
  );

  // The response handshake frees the stage in the same cycle, giving back-to-back accepts.
  assign rsp_done    = (state_q == RESP) & rsp_ready_i;
  assign req_ready_o = (state_q == IDLE) | rsp_done;
  assign accept      = req_valid_i & req_ready_o;
  assign in_access   = (state_q == ACCESS);

  // Next-state and datapath: latch on accept, capture read data in ACCESS.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    size_d      = size_q;
    zext_d      = zext_q;
    vec_d       = vec_q;
    wdata_d     = wdata_q;
    vec_wdata_d = vec_wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    vec_rdata_d = vec_rdata_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ACCESS: begin
        err_d       = 1'b0;
        rdata_d     = (wr_q | vec_q) ? 32'd0 : data_mem_rd_data_i;
        vec_rdata_d = (!wr_q && vec_q) ? vec_mem_rd_data_i : '0;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      wr_d        = req_wr_i;
      addr_d      = req_addr_i;
      size_d      = req_size_i;
      zext_d      = req_zero_extnd_i;
      vec_d       = req_vec_i;
      wdata_d     = req_wdata_i;
      vec_wdata_d = req_vec_wdata_i;
      err_d       = req_err;
      rdata_d     = 32'd0;
      vec_rdata_d = '0;
      state_d     = req_err ? RESP : ACCESS;
    end
  end

  // State and all latched fields, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= 32'd0;
      size_q      <= 2'd0;
      zext_q      <= 1'b0;
      vec_q       <= 1'b0;
      wdata_q     <= 32'd0;
      vec_wdata_q <= '0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      vec_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      zext_q      <= zext_d;
      vec_q       <= vec_d;
      wdata_q     <= wdata_d;
      vec_wdata_q <= vec_wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      vec_rdata_q <= vec_rdata_d;
    end
  end

  // Memory side is quiet outside ACCESS; reset drops state to IDLE at once, so no write commits.
  assign data_req_o         = in_access;
  assign data_wr_o          = in_access & wr_q;
  assign data_addr_o        = in_access ? addr_q : 32'd0;
  assign data_byte_en_o     = in_access ? size_q : 2'd0;
  assign data_zero_extnd_o  = in_access & zext_q;
  assign is_vector_o        = in_access & vec_q;
  assign data_wr_data_o     = in_access ? wdata_q : 32'd0;
  assign vec_data_wr_data_o = in_access ? vec_wdata_q : '0;

  assign rsp_valid_o     = (state_q == RESP);
  assign rsp_err_o       = rsp_valid_o & err_q;
  assign rsp_rdata_o     = rsp_valid_o ? rdata_q : 32'd0;
  assign rsp_vec_rdata_o = rsp_valid_o ? vec_rdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: behavioural data memory, expected-response queue
// and a monitor that pops and compares on every response handshake.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
  import yarp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid_i, req_ready_o, req_wr_i, req_zero_extnd_i, req_vec_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  vec_data_t   req_vec_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  vec_data_t   rsp_vec_rdata_o;
  logic        data_req_o, data_wr_o, data_zero_extnd_o, is_vector_o;
  logic [31:0] data_addr_o, data_wr_data_o;
  logic [1:0]  data_byte_en_o;
  vec_data_t   vec_data_wr_data_o;
  logic [31:0] data_mem_rd_data_i = 32'd0;
  vec_data_t   vec_mem_rd_data_i = '0;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_wr_i           (req_wr_i),
    .req_addr_i         (req_addr_i),
    .req_size_i         (req_size_i),
    .req_zero_extnd_i   (req_zero_extnd_i),
    .req_vec_i          (req_vec_i),
    .req_wdata_i        (req_wdata_i),
    .req_vec_wdata_i    (req_vec_wdata_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_err_o          (rsp_err_o),
    .rsp_rdata_o        (rsp_rdata_o),
    .rsp_vec_rdata_o    (rsp_vec_rdata_o),
    .data_req_o         (data_req_o),
    .data_wr_o          (data_wr_o),
    .data_addr_o        (data_addr_o),
    .data_byte_en_o     (data_byte_en_o),
    .data_zero_extnd_o  (data_zero_extnd_o),
    .is_vector_o        (is_vector_o),
    .data_wr_data_o     (data_wr_data_o),
    .vec_data_wr_data_o (vec_data_wr_data_o),
    .data_mem_rd_data_i (data_mem_rd_data_i),
    .vec_mem_rd_data_i  (vec_mem_rd_data_i)
  );

  // ---------------- data memory model ----------------
  logic [7:0] mem [0:511];
  logic       mem_init_done = 1'b0;

  function automatic logic [7:0] mb(input int a);
    logic [8:0] ix;
    ix = a[8:0];
    return mem[ix];
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [1:0] sz, input logic zx);
    logic [7:0] b0, b1, b2, b3;
    int base;
    base = int'(a[8:0]);
    b0 = mb(base); b1 = mb(base + 1); b2 = mb(base + 2); b3 = mb(base + 3);
    case (sz)
      2'd0:    return zx ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return zx ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic vec_data_t model_vrd(input logic [31:0] a);
    vec_data_t v;
    int row;
    row = int'(a[8:4]);
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 16; k++)
        v[r][8*k +: 8] = mb((((row + r) % 32) * 16) + k);
    return v;
  endfunction

  // Writes commit on the edge that ends the ACCESS cycle.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
      mem_init_done <= 1'b1;
    end else if (data_req_o && data_wr_o) begin
      if (is_vector_o) begin
        for (int r = 0; r < 4; r++)
          for (int k = 0; k < 16; k++)
            mem[9'((((int'(data_addr_o[8:4]) + r) % 32) * 16) + k)] <= vec_data_wr_data_o[r][8*k +: 8];
      end else begin
        mem[data_addr_o[8:0]] <= data_wr_data_o[7:0];
        if (data_byte_en_o != 2'd0) mem[data_addr_o[8:0] + 9'd1] <= data_wr_data_o[15:8];
        if (data_byte_en_o == 2'd2) begin
          mem[data_addr_o[8:0] + 9'd2] <= data_wr_data_o[23:16];
          mem[data_addr_o[8:0] + 9'd3] <= data_wr_data_o[31:24];
        end
      end
    end
  end

  // Read data presented mid-cycle from the current memory-side request.
  always @(negedge clk) begin
    data_mem_rd_data_i <= model_rd(data_addr_o, data_byte_en_o, data_zero_extnd_o);
    vec_mem_rd_data_i  <= model_vrd(data_addr_o);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rd;
    vec_data_t   vrd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;
  int   n_dreq  = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic expect_rsp(input string nm, input logic e, input logic [31:0] rd, input vec_data_t vrd);
    exp_t x;
    x.name = nm; x.err = e; x.rd = rd; x.vrd = vrd;
    exp_q.push_back(x);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_req_o) n_dreq++;
      if (reset_n && rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got response err=%0b rdata=%0h with empty queue", rsp_err_o, rsp_rdata_o);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_err"},   512'(rsp_err_o),   512'(e.err));
          chk({e.name, "_rdata"}, 512'(rsp_rdata_o), 512'(e.rd));
          chk({e.name, "_vdata"}, rsp_vec_rdata_o,   e.vrd);
        end
        n_rsp++;
      end
    end
  endtask

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                           input logic zx, input logic vec, input logic [31:0] wd, input vec_data_t vwd);
    bit ok;
    req_wr_i = wr; req_addr_i = addr; req_size_i = size; req_zero_extnd_i = zx;
    req_vec_i = vec; req_wdata_i = wd; req_vec_wdata_i = vwd; req_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int tgt, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (n_rsp >= tgt) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now({nm, "_rsp_timeout"});
  endtask

  task automatic do_req(input string nm, input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic zx, input logic vec, input logic [31:0] wd, input vec_data_t vwd,
                        input logic e_err, input logic [31:0] e_rd, input vec_data_t e_vrd);
    int tgt, d0;
    expect_rsp(nm, e_err, e_rd, e_vrd);
    start_req(wr, addr, size, zx, vec, wd, vwd);
    tgt = n_rsp + 1;
    d0  = n_dreq;
    @(negedge clk);
    chk({nm, "_n1_data_req"}, 512'(data_req_o), 512'(!e_err));
    chk({nm, "_n1_rsp_valid"}, 512'(rsp_valid_o), 512'(e_err));
    if (!e_err) begin
      @(negedge clk);
      chk({nm, "_n2_rsp_valid"}, 512'(rsp_valid_o), 512'(1'b1));
      chk({nm, "_n2_data_req"}, 512'(data_req_o), 512'(1'b0));
    end
    wait_rsp(tgt, nm);
    chk({nm, "_access_cycles"}, 512'(n_dreq - d0), e_err ? 512'(0) : 512'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_data_t v0, vpat;
  int        tgt;

  initial begin
    v0 = '0;
    vpat[0] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    vpat[1] = 128'h11111111_22222222_33333333_44444444;
    vpat[2] = 128'ha5a5a5a5_5a5a5a5a_12345678_9abcdef0;
    vpat[3] = 128'hcafef00d_33333333_33333332_33333331;

    req_valid_i = 1'b0; req_wr_i = 1'b0; req_addr_i = 32'd0; req_size_i = 2'd0;
    req_zero_extnd_i = 1'b0; req_vec_i = 1'b0; req_wdata_i = 32'd0; req_vec_wdata_i = '0;
    rsp_ready_i = 1'b1;

    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 512'(req_ready_o), 512'(1'b1));
    chk("reset_rsp_valid", 512'(rsp_valid_o), 512'(1'b0));
    chk("reset_data_req",  512'(data_req_o),  512'(1'b0));
    chk("reset_rsp_err",   512'(rsp_err_o),   512'(1'b0));
    chk("reset_rsp_rdata", 512'(rsp_rdata_o), 512'(0));
    @(posedge clk); #1;

    // Scalar round trips and extension.
    do_req("st_word_10", 1'b1, 32'h10, WORD, 1'b0, 1'b0, 32'hDEADBEEF, v0, 1'b0, 32'h0, v0);
    do_req("ld_word_10", 1'b0, 32'h10, WORD, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'hDEADBEEF, v0);
    do_req("st_byte_3", 1'b1, 32'h3, BYTE, 1'b0, 1'b0, 32'h00000080, v0, 1'b0, 32'h0, v0);
    do_req("ld_byte_3_sx", 1'b0, 32'h3, BYTE, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'hFFFFFF80, v0);
    do_req("ld_byte_3_zx", 1'b0, 32'h3, BYTE, 1'b1, 1'b0, 32'h0, v0, 1'b0, 32'h00000080, v0);
    do_req("ld_half_2_sx", 1'b0, 32'h2, HALF_WORD, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'hFFFF8000, v0);

    // Misaligned accesses: rejected only when the alignment checks are built in.
`ifdef LSU_MISALIGN_CHK_EN
    do_req("ld_half_5", 1'b0, 32'h5, HALF_WORD, 1'b0, 1'b0, 32'h0, v0, 1'b1, 32'h0, v0);
    do_req("ld_word_12", 1'b0, 32'h12, WORD, 1'b0, 1'b0, 32'h0, v0, 1'b1, 32'h0, v0);
`else
    do_req("ld_half_5", 1'b0, 32'h5, HALF_WORD, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'h0, v0);
    do_req("ld_word_12", 1'b0, 32'h12, WORD, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'h0000DEAD, v0);
`endif

    // Vector range boundary and round trip.
    do_req("vst_1d0", 1'b1, 32'h1D0, WORD, 1'b0, 1'b1, 32'h0, vpat, 1'b1, 32'h0, v0);
    do_req("vst_1c0", 1'b1, 32'h1C0, WORD, 1'b0, 1'b1, 32'h0, vpat, 1'b0, 32'h0, v0);
    do_req("vld_1c0", 1'b0, 32'h1C0, WORD, 1'b0, 1'b1, 32'h0, v0, 1'b0, 32'h0, vpat);
`ifdef LSU_MISALIGN_CHK_EN
    do_req("vld_1c4", 1'b0, 32'h1C4, WORD, 1'b0, 1'b1, 32'h0, v0, 1'b1, 32'h0, v0);
`else
    do_req("vld_1c4", 1'b0, 32'h1C4, WORD, 1'b0, 1'b1, 32'h0, v0, 1'b0, 32'h0, vpat);
`endif

    // Scalar range boundary.
    do_req("ld_word_1fc", 1'b0, 32'h1FC, WORD, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'hCAFEF00D, v0);
    do_req("ld_byte_1ff", 1'b0, 32'h1FF, BYTE, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'hFFFFFFCA, v0);
    do_req("ld_word_200", 1'b0, 32'h200, WORD, 1'b0, 1'b0, 32'h0, v0, 1'b1, 32'h0, v0);

    // Response stall then back-to-back accept.
    rsp_ready_i = 1'b0;
    expect_rsp("stall_ld_10", 1'b0, 32'hDEADBEEF, v0);
    start_req(1'b0, 32'h10, WORD, 1'b0, 1'b0, 32'h0, v0);
    tgt = n_rsp + 2;
    @(negedge clk);
    chk("stall_access_req_ready", 512'(req_ready_o), 512'(1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 512'(rsp_valid_o), 512'(1'b1));
      chk("stall_rsp_rdata", 512'(rsp_rdata_o), 512'(32'hDEADBEEF));
      chk("stall_rsp_err",   512'(rsp_err_o),   512'(1'b0));
      chk("stall_req_ready", 512'(req_ready_o), 512'(1'b0));
    end
    @(posedge clk); #1;
    expect_rsp("b2b_ld_byte_3", 1'b0, 32'h00000080, v0);
    req_wr_i = 1'b0; req_addr_i = 32'h3; req_size_i = BYTE; req_zero_extnd_i = 1'b1;
    req_vec_i = 1'b0; req_valid_i = 1'b1; rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("b2b_req_ready", 512'(req_ready_o), 512'(1'b1));
    chk("b2b_rsp_valid", 512'(rsp_valid_o), 512'(1'b1));
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_access_next", 512'(data_req_o), 512'(1'b1));
    chk("b2b_access_rsp_valid", 512'(rsp_valid_o), 512'(1'b0));
    wait_rsp(tgt, "b2b");

    // Reset during the ACCESS cycle of a store must suppress the write.
    do_req("st_word_20", 1'b1, 32'h20, WORD, 1'b0, 1'b0, 32'h11223344, v0, 1'b0, 32'h0, v0);
    start_req(1'b1, 32'h20, WORD, 1'b0, 1'b0, 32'h55667788, v0);
    chk("pre_reset_in_access", 512'(data_req_o), 512'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    chk("rst_data_req",  512'(data_req_o),  512'(1'b0));
    chk("rst_data_wr",   512'(data_wr_o),   512'(1'b0));
    chk("rst_data_addr", 512'(data_addr_o), 512'(0));
    chk("rst_req_ready", 512'(req_ready_o), 512'(1'b1));
    chk("rst_rsp_valid", 512'(rsp_valid_o), 512'(1'b0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    do_req("ld_word_20", 1'b0, 32'h20, WORD, 1'b0, 1'b0, 32'h0, v0, 1'b0, 32'h11223344, v0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 512'(exp_q.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store control stage that sits directly upstream of the data memory. It accepts one scalar or vector memory request at a time from execute over a valid/ready handshake and checks alignment and address range. It then drives the data memory port for exactly one cycle, registers the read data, and returns a response to writeback over a second valid/ready handshake.

## Interface
- No parameters. Depth and row constants come from `yarp_pkg`.
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  1  request valid from execute
- `req_ready_o`  out  1  stage can accept a request
- `req_wr_i`  in  1  1 = store, 0 = load
- `req_addr_i`  in  32  byte address
- `req_size_i`  in  2  BYTE / HALF_WORD / WORD from `yarp_pkg`
- `req_zero_extnd_i`  in  1  zero-extend a scalar load
- `req_vec_i`  in  1  4×128-bit vector access
- `req_wdata_i`  in  32  scalar store data
- `req_vec_wdata_i`  in  128×[4]  vector store data
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  writeback accepts the response
- `rsp_err_o`  out  1  request was rejected; no memory access took place
- `rsp_rdata_o`  out  32  scalar load data; 0 for stores and errors
- `rsp_vec_rdata_o`  out  128×[4]  vector load data; 0 otherwise
- `data_req_o`, `data_wr_o`, `data_addr_o[31:0]`, `data_byte_en_o[1:0]`, `data_zero_extnd_o`, `is_vector_o`, `data_wr_data_o[31:0]`, `vec_data_wr_data_o[128×4]`  out  memory-side request, one cycle per access
- `data_mem_rd_data_i`  in  32  scalar read data; already extended by memory
- `vec_mem_rd_data_i`  in  128×[4]  vector read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - `req_ready_o=1`.
  - On `req_valid_i`, latch all request fields into registers.
  - Evaluate errors:
    - misaligned: HALF_WORD with addr[0]≠0; WORD with addr[1:0]≠0; vector with addr[3:0]≠0.
    - out of range: scalar with addr ≥ 0x200; vector with addr[31:4] > 28.
  - No error: go to ACCESS. Error: go to RESP with `rsp_err_o=1`.
- **ACCESS**
  - `data_req_o=1`, and all memory outputs come from the latched registers.
  - At the end of the cycle, the memory commits any write, and the stage captures read data into the response registers.
  - Then go to RESP.
- **RESP**
  - `rsp_valid_o=1`. All `rsp_*` outputs stay stable until `rsp_ready_i`.
  - With `rsp_valid_o & rsp_ready_i`:
    - `req_ready_o` is also high in this cycle.
    - If `req_valid_i` is also high, accept the new request and go to ACCESS (or to RESP on error).
    - Otherwise go to IDLE.
- Stores return a response with zero data (completion acknowledge).
- Scalar write data passes through unmodified; the memory selects the byte lanes.
- Memory-side outputs are 0 in every state other than ACCESS.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - `req_ready_o=1`.
  - All other outputs = 0.
  - All latched fields and response registers = 0.
- Reset asserted during ACCESS deasserts `data_req_o` combinationally, so no write commits.
- Latency: accept at edge N → ACCESS in cycle N+1 → `rsp_valid_o` in cycle N+2.
- Error path: `rsp_valid_o` in cycle N+1. `data_req_o` is never asserted.
- Throughput: one request per 2 cycles with `rsp_ready_i` held high.
- `req_ready_o` is 0 during ACCESS and during RESP without `rsp_ready_i`.

## Configuration
- `LSU_MISALIGN_CHK_EN` defined: the alignment checks above are active.
- Not defined: the alignment checks are removed, and the address passes unmodified to memory. Range checks remain in both builds.

## Structure
- Add to `yarp_pkg`:
  - `lsu_state_t` enum (IDLE, ACCESS, RESP)
  - `DMEM_ROWS = 32`
  - `VEC_ROWS = 4`
  - `DMEM_BYTES = 512`
- One sub-module, `lsu_addr_check`: purely combinational; inputs addr, size and vec; output err.

## Test plan
- Store WORD 0xDEADBEEF to 0x10, then load WORD from 0x10 → `data_req_o` high exactly one cycle each; load `rsp_rdata_o=0xDEADBEEF` at N+2; `rsp_err_o=0`.
- Store BYTE 0x80 to 0x3, then load BYTE from 0x3 with `zero_extnd=0` → 0xFFFFFF80. Repeat the load with `zero_extnd=1` → 0x00000080.
- Load HALF_WORD from 0x5 → with macro: `rsp_err_o=1` at N+1 and no `data_req_o`. Without macro: memory access occurs and `rsp_err_o=0`.
- Vector store to 0x1D0 (row 29) → `rsp_err_o=1`, no access. Vector store/load at 0x1C0 → four rows round-trip intact.
- Hold `rsp_ready_i=0` for 5 cycles after a load → `rsp_*` stable and `req_ready_o=0` throughout. Release together with a new valid request → back-to-back accept, then ACCESS next cycle.
- Assert `reset_n=0` mid-ACCESS of a store to 0x20 → outputs clear immediately; a later load of 0x20 returns the old value.
